// File: rtl/debug_mem_port.sv
// Debug command port that reads and writes instruction RAM port b through an auto-incrementing word pointer.
// Optional: define DEBUG_PORT_CHECKSUM_EN to build the write-data checksum that op 11 returns and clears.
module debug_mem_port #(
    parameter int AUTO_INC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [29:0] addrb,
    output logic [31:0] dinb,
    output logic        web,
    input  logic [31:0] doutb,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_WAIT,
        RD_CAP,
        RESP
    } state_t;

    localparam logic [1:0] OP_SET_ADDR = 2'b00;
    localparam logic [1:0] OP_WRITE    = 2'b01;
    localparam logic [1:0] OP_READ     = 2'b10;
    localparam logic [1:0] OP_SPECIAL  = 2'b11;

    state_t      state_reg;
    state_t      state_next;
    logic [29:0] ptr_reg;
    logic [31:0] dinb_reg;
    logic        web_reg;
    logic        rsp_valid_reg;
    logic [31:0] rsp_data_reg;
    logic        accept;
    logic        ptr_step;

    assign accept    = cmd_valid && (state_reg == IDLE);
    assign cmd_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign addrb     = ptr_reg;
    assign dinb      = dinb_reg;
    assign web       = web_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;

    // The pointer advances when a write retires (WR) or a read word is captured (RD_CAP).
    assign ptr_step  = (AUTO_INC != 0) && ((state_reg == WR) || (state_reg == RD_CAP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WRITE: state_next = WR;
                        OP_READ:  state_next = RD_WAIT;
`ifdef DEBUG_PORT_CHECKSUM_EN
                        OP_SPECIAL: state_next = RESP;
`endif
                        default:  state_next = IDLE;
                    endcase
                end
            end
            WR:      state_next = IDLE;
            RD_WAIT: state_next = RD_CAP;
            RD_CAP:  state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef DEBUG_PORT_CHECKSUM_EN
    logic [31:0] sum_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg <= 32'd0;
        end else if (accept && (cmd_op == OP_WRITE)) begin
            sum_reg <= sum_reg + cmd_data;
        end else if (accept && (cmd_op == OP_SPECIAL)) begin
            sum_reg <= 32'd0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= 30'd0;
        end else if (accept && (cmd_op == OP_SET_ADDR)) begin
            ptr_reg <= cmd_data[31:2];
        end else if (ptr_step) begin
            ptr_reg <= ptr_reg + 30'd1;
        end
    end

    // web is a flop so that it is high for exactly the single WR cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            web_reg  <= 1'b0;
            dinb_reg <= 32'd0;
        end else begin
            web_reg <= accept && (cmd_op == OP_WRITE);
            if (accept && (cmd_op == OP_WRITE)) begin
                dinb_reg <= cmd_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= 32'd0;
        end else if (state_reg == RD_CAP) begin
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= doutb;
`ifdef DEBUG_PORT_CHECKSUM_EN
        end else if (accept && (cmd_op == OP_SPECIAL)) begin
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= sum_reg;
`endif
        end else if ((state_reg == RESP) && rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_debug_mem_port.sv
// Randomized bench for debug_mem_port: transaction-level model of pointer, memory and checksum,
// compared against the DUT every cycle, plus hand-computed directed expectations.
module tb_debug_mem_port;

    localparam int AUTO_INC = 1;
    localparam int DEPTH    = 64;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [29:0] addrb;
    logic [31:0] dinb;
    logic        web;
    logic [31:0] doutb;
    logic        busy;

    debug_mem_port #(.AUTO_INC(AUTO_INC)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .addrb(addrb), .dinb(dinb), .web(web), .doutb(doutb), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B9) + 32'h0123_4567;
    endfunction

    // Instruction RAM on port b: registered read, out-of-range reads return 0, writes ignored.
    logic [31:0] ram [DEPTH];
    logic        ram_fill;
    always @(posedge clk) begin
        if (ram_fill) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
        end else if (web && (addrb < 30'(DEPTH))) begin
            ram[addrb[5:0]] <= dinb;
        end
        doutb <= (addrb < 30'(DEPTH)) ? ram[addrb[5:0]] : 32'd0;
    end

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model state
    logic [29:0] m_ptr;
    logic [31:0] m_sum;
    logic [31:0] ref_mem [DEPTH];
    logic        exp_ready;
    logic        exp_web;
    logic [31:0] exp_dinb;
    logic        exp_rsp_valid;
    logic [31:0] exp_rsp_data;
    logic        chk_en;
    int          web_cnt;

    function automatic logic [31:0] ref_read(input logic [29:0] p);
        return (p < 30'(DEPTH)) ? ref_mem[p[5:0]] : 32'd0;
    endfunction

    always @(negedge clk) begin
        if (web) web_cnt++;
        if (chk_en) begin
            check("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
            check("busy",      32'(busy),      32'(!exp_ready));
            check("addrb",     32'(addrb),     32'(m_ptr));
            check("web",       32'(web),       32'(exp_web));
            check("dinb",      dinb,           exp_dinb);
            check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
            check("rsp_data",  rsp_data,       exp_rsp_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_cmd();
        cmd_valid = 1'b1;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_data  = $urandom;
    endtask

    task automatic idle_cmd();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_data  = $urandom;
    endtask

    task automatic set_addr(input logic [31:0] a);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = a;
        step();
        idle_cmd();
        m_ptr = a[31:2];
    endtask

    task automatic wr(input logic [31:0] d);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = d;
        step();
        junk_cmd();
        exp_ready = 1'b0; exp_web = 1'b1; exp_dinb = d;
        if (m_ptr < 30'(DEPTH)) ref_mem[m_ptr[5:0]] = d;
        m_sum = m_sum + d;
        step();
        idle_cmd();
        exp_web = 1'b0; exp_ready = 1'b1;
        if (AUTO_INC != 0) m_ptr = m_ptr + 30'd1;
    endtask

    // Response sits in RESP for 'hold' cycles with rsp_ready low, then is consumed.
    task automatic finish_resp(input int hold);
        rsp_ready = 1'b0;
        repeat (hold) step();
        rsp_ready = 1'b1;
        step();
        idle_cmd();
        rsp_ready = 1'($urandom_range(0, 1));
        exp_rsp_valid = 1'b0; exp_ready = 1'b1;
    endtask

    task automatic rd(input int hold, output logic [31:0] rdata);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_data = $urandom;
        step();
        junk_cmd();
        rsp_ready = 1'($urandom_range(0, 1));
        exp_ready = 1'b0;
        step();
        rsp_ready = 1'($urandom_range(0, 1));
        step();
        exp_rsp_valid = 1'b1;
        exp_rsp_data  = ref_read(m_ptr);
        rdata = exp_rsp_data;
        if (AUTO_INC != 0) m_ptr = m_ptr + 30'd1;
        finish_resp(hold);
    endtask

    task automatic special(input int hold, output logic [31:0] rdata);
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = $urandom;
        step();
`ifdef DEBUG_PORT_CHECKSUM_EN
        junk_cmd();
        exp_ready = 1'b0; exp_rsp_valid = 1'b1; exp_rsp_data = m_sum;
        rdata = m_sum;
        m_sum = 32'd0;
        finish_resp(hold);
`else
        idle_cmd();
        rdata = 32'd0;
        if (hold < 0) rdata = 32'hFFFF_FFFF;
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        int          wc;
        rst_n = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 32'd0; rsp_ready = 1'b0;
        chk_en = 1'b0; web_cnt = 0; ram_fill = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        #2 rst_n = 1'b0;
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_addrb",     32'(addrb),     32'd0);
        check("rst_web",       32'(web),       32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  rsp_data,       32'd0);
        #19 rst_n = 1'b1;
        step();
        ram_fill = 1'b0;
        m_ptr = 30'd0; m_sum = 32'd0;
        exp_ready = 1'b1; exp_web = 1'b0; exp_dinb = 32'd0;
        exp_rsp_valid = 1'b0; exp_rsp_data = 32'd0;
        chk_en = 1'b1;

        // Write through the pointer, then read it back
        set_addr(32'h0000_0010);
        check("set_addrb_0x10", 32'(addrb), 32'h4);
        wc = web_cnt;
        wr(32'hDEAD_BEEF);
        check("wr_dinb",      dinb, 32'hDEAD_BEEF);
        check("wr_web_cycles", 32'(web_cnt - wc), 32'd1);
        check("wr_ptr_inc",   32'(addrb), 32'h5);
        set_addr(32'h0000_0013);
        rd(0, r);
        check("rd_data",    rsp_data, 32'hDEAD_BEEF);
        check("rd_ptr_inc", 32'(addrb), 32'h5);
        set_addr(32'h0000_0010);
        rd(5, r);
        check("rd_hold_data", rsp_data, 32'hDEAD_BEEF);

        // Pointer wrap and out-of-range access
        set_addr(32'hFFFF_FFFC);
        check("top_addrb", 32'(addrb), 32'h3FFF_FFFF);
        wr(32'h0000_0001);
        check("wrap_addrb", 32'(addrb), 32'h0);
        set_addr(32'h0000_1000);
        rd(1, r);
        check("oor_read", rsp_data, 32'h0);

        // Checksum
        special(0, r);
        wr(32'h0000_0001);
        wr(32'hFFFF_FFFF);
        wr(32'h0000_0005);
        special(2, r);
`ifdef DEBUG_PORT_CHECKSUM_EN
        check("csum_first",  rsp_data, 32'h0000_0005);
        special(0, r);
        check("csum_second", rsp_data, 32'h0000_0000);
`else
        check("special_no_rsp", 32'(rsp_valid), 32'd0);
`endif

        // Reset during WR
        set_addr(32'h0000_0020);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 32'hA5A5_5A5A;
        step();
        cmd_valid = 1'b0;
        check("wr_web_before_rst", 32'(web), 32'd1);
        chk_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_wr_web",   32'(web),   32'd0);
        check("rst_wr_addrb", 32'(addrb), 32'd0);
        check("rst_wr_dinb",  dinb,       32'd0);
        check("rst_wr_busy",  32'(busy),  32'd0);
        #1 rst_n = 1'b1;
        step();
        m_ptr = 30'd0; m_sum = 32'd0;
        exp_ready = 1'b1; exp_web = 1'b0; exp_dinb = 32'd0;
        exp_rsp_valid = 1'b0; exp_rsp_data = 32'd0;
        chk_en = 1'b1;
        rd(0, r);
        check("rd_after_rst", rsp_data, init_word(0));

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 2) begin
                if ($urandom_range(0, 3) == 0)
                    set_addr(32'hFFFF_FFE0 | 32'($urandom_range(0, 31)));
                else
                    set_addr(32'($urandom_range(0, (DEPTH + 8) * 4 - 1)));
            end else if (sel < 5) begin
                wr($urandom);
            end else if (sel < 8) begin
                rd($urandom_range(0, 4), r);
            end else if (sel < 9) begin
                special($urandom_range(0, 3), r);
            end else begin
                idle_cmd();
                rsp_ready = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 3)) step();
            end
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/debug_mem_port.md
DEBUG_MEM_PORT -- requirements
Module: debug_mem_port

Interface
REQ-001 Parameter AUTO_INC, default 1: nonzero makes the address pointer post-increment after every completed write or read; 0 holds it.
REQ-002 clk  input  1  sole clock; all logic updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-006 cmd_op  input  2  encoding: 00 set address, 01 write, 10 read, 11 special.
REQ-007 cmd_data  input  32  byte address (op 00) or write data (op 01); ignored otherwise.
REQ-008 rsp_valid  output  1  read/special response held.
REQ-009 rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-010 rsp_data  output  32  response word.
REQ-011 addrb  output  30  word address [31:2] to instruction RAM port b.
REQ-012 dinb  output  32  port b write data.
REQ-013 web  output  1  port b write enable, whole-word.
REQ-014 doutb  input  32  port b read data, valid one clk after addrb is sampled.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, WR, RD_WAIT, RD_CAP, RESP; cmd_ready = 1 only in IDLE.
REQ-017 addrb continuously equals the 30-bit pointer register ptr.
REQ-018 Op 00 accepted at edge N: ptr <= cmd_data[31:2] at N; cmd_data[1:0] ignored; FSM stays IDLE; no port b access.
REQ-019 Op 01 accepted at edge N: dinb <= cmd_data, web <= 1, state WR; at N+1: web <= 0, ptr increments (if AUTO_INC), state IDLE; web is high for exactly one cycle.
REQ-020 Op 10 accepted at edge N: state RD_WAIT; N+1: RD_CAP; N+2: rsp_data <= doutb, rsp_valid <= 1, ptr increments (if AUTO_INC), state RESP.
REQ-021 RESP: rsp_valid and rsp_data held stable until rsp_ready; at the handshake edge rsp_valid <= 0, state IDLE; no new command accepted in that same cycle.
REQ-022 rsp_ready high with rsp_valid low has no effect.
REQ-023 ptr increments modulo 2^30: 0x3FFFFFFF wraps to 0x00000000.
REQ-024 Out-of-range pointers are still driven on addrb; the RAM's own range check governs the result (a read returns 0).
REQ-025 web is never high outside WR; web and a read never overlap.
REQ-026 Op 11 behaviour per Configuration.

Reset
REQ-027 rst_n low forces immediately: state IDLE, ptr 0, web 0, dinb 0, rsp_valid 0, rsp_data 0, busy 0, checksum 0.
REQ-028 Reset during WR deasserts web without waiting for the clk edge; reset during RD_*/RESP discards the pending response.
REQ-029 The first command is accepted no earlier than the first rising edge after rst_n rises.

Configuration
REQ-030 Macro DEBUG_PORT_CHECKSUM_EN defined: a 32-bit register accumulates the wrapping sum of every written word; op 11 moves to RESP with rsp_data = the sum one edge after acceptance, then clears the sum.
REQ-031 Macro not defined: no accumulator is built; op 11 is accepted, produces no response, and leaves the FSM in IDLE.

Verification
REQ-032 Op00 0x00000010, op01 0xDEADBEEF -> addrb 0x4, dinb 0xDEADBEEF, web high exactly 1 cycle; ptr then 0x5.
REQ-033 Op00 0x10, op10 with doutb model returning 0xDEADBEEF -> rsp_valid 2 cycles after acceptance, rsp_data 0xDEADBEEF, ptr 0x5.
REQ-034 Read response with rsp_ready held low 5 cycles -> rsp_valid/rsp_data stable, cmd_ready 0 throughout; released one cycle after rsp_ready.
REQ-035 Op00 0xFFFFFFFC, op01 0x1 -> addrb 0x3FFFFFFF, then ptr 0x00000000.
REQ-036 rst_n pulsed low during WR -> web low asynchronously, ptr 0, next op10 returns from address 0.
REQ-037 With DEBUG_PORT_CHECKSUM_EN: writes 0x1, 0xFFFFFFFF, 0x5 then op11 -> rsp_data 0x00000005; a second op11 -> 0x00000000. Without it: op11 yields no rsp_valid.
